// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
// Purpose: controller state encoding, register-address width, word-alignment constant.
// Ports:   none (package).
package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;

    // Byte-offset bits cleared to form a word-aligned bus address.
    localparam int WORD_LSB = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_dmem_ctrl.sv
// rtl/mem_stage_dmem_ctrl.sv - data-memory access controller (FSM, bus regs, timeout)
// Purpose: runs the req/ack handshake for one load or store and stalls the pipeline until it completes.
// Optional feature: MEM_STAGE_TIMEOUT_EN adds a REQ-cycle counter that forces completion.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_memop, i_we         access request from EX/MEM and its direction (1 = write)
//   i_addr, i_wdata       byte address and store data from EX/MEM
//   i_ack                 bus access complete
//   o_req, o_we           bus request (held until ack) and direction
//   o_addr, o_wdata       registered word-aligned address and store data
//   o_stall               freeze upstream stages
//   o_pass                IDLE with no memop: MEM/WB takes the inputs directly
//   o_done                access finished this cycle (ack or forced)
//   o_timeout             this completion was forced by the timeout
//   o_err_timeout         sticky timeout flag
module M_dmem_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_memop,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_stall,
    output logic              o_pass,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_err_timeout
);
    import mem_stage_pkg::*;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              timeout_hit;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter is zero in the first REQ cycle and counts REQ cycles seen without ack.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_REQ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == S_REQ) && !i_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        err_d = err_q | timeout_hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err_timeout = err_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit   = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        o_stall   = 1'b0;
        o_pass    = 1'b0;
        o_done    = 1'b0;
        o_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_memop) begin
                    we_d    = i_we;
                    addr_d  = {i_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
                    wdata_d = i_wdata;
                    o_stall = 1'b1;
                    state_d = S_REQ;
                end else begin
                    o_pass = 1'b1;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    o_done    = 1'b1;
                    o_timeout = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_req   = (state_q == S_REQ);
    assign o_we    = we_q;
    assign o_addr  = addr_q;
    assign o_wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access, MEM/WB register, W-stage feedback
// Purpose: issues the load/store for the EX/MEM instruction, stalls until done, then loads MEM/WB.
// Optional feature: MEM_STAGE_TIMEOUT_EN (bus timeout with sticky o_err_timeout).
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_data_pc4/alures/rt, i_addr_regdst EX/MEM data and destination register
//   i_con_M*, i_con_W*                 memory and write-back controls
//   o_dmem_*, i_dmem_*                 req/ack data-memory bus
//   o_con_stall                        freeze IF/ID/EX and EX/MEM
//   o_data_memout/result, o_addr_Wrd, o_con_W*  MEM/WB register
//   o_err_timeout                      sticky bus-timeout flag
module mem_stage #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data_pc4,
    input  logic [DATA_W-1:0] i_data_alures,
    input  logic [DATA_W-1:0] i_data_rt,
    input  logic [4:0]        i_addr_regdst,
    input  logic              i_con_Mmemread,
    input  logic              i_con_Mmemwrite,
    input  logic              i_con_Malupc8,
    input  logic              i_con_Wmemtoreg,
    input  logic              i_con_Wregwrite,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic              o_con_stall,
    output logic [DATA_W-1:0] o_data_memout,
    output logic [DATA_W-1:0] o_data_result,
    output logic [4:0]        o_addr_Wrd,
    output logic              o_con_Wmemtoreg,
    output logic              o_con_Wregwrite,
    output logic              o_err_timeout
);
    import mem_stage_pkg::*;

    logic                  memop;
    logic                  pass;
    logic                  done;
    logic                  timeout;
    logic [DATA_W-1:0]     result_mux;

    logic [DATA_W-1:0]     memout_q, memout_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [REG_ADDR_W-1:0] wrd_q, wrd_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  regwrite_q, regwrite_d;

    assign memop = i_con_Mmemread | i_con_Mmemwrite;

    M_dmem_ctrl #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dmem_ctrl (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_memop       (memop),
        .i_we          (i_con_Mmemwrite),
        .i_addr        (i_data_alures[ADDR_W-1:0]),
        .i_wdata       (i_data_rt),
        .i_ack         (i_dmem_ack),
        .o_req         (o_dmem_req),
        .o_we          (o_dmem_we),
        .o_addr        (o_dmem_addr),
        .o_wdata       (o_dmem_wdata),
        .o_stall       (o_con_stall),
        .o_pass        (pass),
        .o_done        (done),
        .o_timeout     (timeout),
        .o_err_timeout (o_err_timeout)
    );

    assign result_mux = i_con_Malupc8 ? (i_data_pc4 + DATA_W'(4)) : i_data_alures;

    // Anything other than a pass-through or a completed access writes a bubble.
    always_comb begin
        memout_d   = '0;
        result_d   = '0;
        wrd_d      = '0;
        memtoreg_d = 1'b0;
        regwrite_d = 1'b0;
        if (pass || done) begin
            result_d   = result_mux;
            wrd_d      = i_addr_regdst;
            memtoreg_d = i_con_Wmemtoreg;
            regwrite_d = i_con_Wregwrite & !timeout;
            // Stores and forced completions return no data.
            if (done && i_dmem_ack && !o_dmem_we) begin
                memout_d = i_dmem_rdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            memout_q   <= '0;
            result_q   <= '0;
            wrd_q      <= '0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
        end else begin
            memout_q   <= memout_d;
            result_q   <= result_d;
            wrd_q      <= wrd_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign o_data_memout   = memout_q;
    assign o_data_result   = result_q;
    assign o_addr_Wrd      = wrd_q;
    assign o_con_Wmemtoreg = memtoreg_q;
    assign o_con_Wregwrite = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc4, alures, rt, rdata;
    logic [4:0]  regdst;
    logic        mread, mwrite, alupc8, m2r, rw;
    logic        ack;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] memout, result;
    logic [4:0]  wrd;
    logic        o_m2r, o_rw, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_data_pc4      (pc4),
        .i_data_alures   (alures),
        .i_data_rt       (rt),
        .i_addr_regdst   (regdst),
        .i_con_Mmemread  (mread),
        .i_con_Mmemwrite (mwrite),
        .i_con_Malupc8   (alupc8),
        .i_con_Wmemtoreg (m2r),
        .i_con_Wregwrite (rw),
        .o_dmem_req      (req),
        .o_dmem_we       (we),
        .o_dmem_addr     (addr),
        .o_dmem_wdata    (wdata),
        .i_dmem_ack      (ack),
        .i_dmem_rdata    (rdata),
        .o_con_stall     (stall),
        .o_data_memout   (memout),
        .o_data_result   (result),
        .o_addr_Wrd      (wrd),
        .o_con_Wmemtoreg (o_m2r),
        .o_con_Wregwrite (o_rw),
        .o_err_timeout   (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        pc4 = 0; alures = 0; rt = 0; rdata = 0; regdst = 0;
        mread = 0; mwrite = 0; alupc8 = 0; m2r = 0; rw = 0; ack = 0;
    endtask

    // One EX/MEM instruction from presentation to MEM/WB write; waits = REQ cycles before ack.
    task automatic do_op(input logic [31:0] t_pc4, input logic [31:0] t_alu, input logic [31:0] t_rt,
                         input logic [31:0] t_rdata, input logic [4:0] t_rd,
                         input logic t_rd_op, input logic t_wr_op, input logic t_pc8,
                         input logic t_m2r, input logic t_rw, input int waits, input logic idle_ack);
        logic        is_mem;
        logic [31:0] exp_result, exp_addr, exp_memout;
        is_mem     = t_rd_op | t_wr_op;
        exp_result = t_pc8 ? t_pc4 + 32'd4 : t_alu;
        exp_addr   = t_alu & 32'hFFFF_FFFC;
        exp_memout = t_wr_op ? 32'd0 : t_rdata;
        pc4 = t_pc4; alures = t_alu; rt = t_rt; rdata = t_rdata; regdst = t_rd;
        mread = t_rd_op; mwrite = t_wr_op; alupc8 = t_pc8; m2r = t_m2r; rw = t_rw;
        ack = is_mem ? 1'b0 : idle_ack;
        #1;
        if (!is_mem) begin
            check("alu_stall", stall, 0);
            check("alu_req", req, 0);
            step;
            ack = 0;
            check("alu_result", result, exp_result);
            check("alu_wrd", wrd, t_rd);
            check("alu_rw", o_rw, t_rw);
            check("alu_m2r", o_m2r, t_m2r);
            check("alu_memout", memout, 0);
        end else begin
            check("idle_stall", stall, 1);
            check("idle_req", req, 0);
            step;
            check("bubble_rw", o_rw, 0);
            check("bubble_m2r", o_m2r, 0);
            check("req_on", req, 1);
            check("req_addr", addr, exp_addr);
            check("req_we", we, t_wr_op);
            if (t_wr_op) check("req_wdata", wdata, t_rt);
            for (int i = 0; i < waits; i++) begin
                check("wait_stall", stall, 1);
                step;
                check("wait_req", req, 1);
                check("wait_addr", addr, exp_addr);
            end
            ack = 1;
            #1;
            check("ack_stall", stall, 0);
            step;
            ack = 0;
            check("done_req", req, 0);
            check("done_result", result, exp_result);
            check("done_wrd", wrd, t_rd);
            check("done_rw", o_rw, t_rw);
            check("done_m2r", o_m2r, t_m2r);
            check("done_memout", memout, exp_memout);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        step;
        step;
        check("rst_req", req, 0);
        check("rst_stall", stall, 0);
        check("rst_result", result, 0);
        check("rst_memout", memout, 0);
        check("rst_rw", o_rw, 0);
        check("rst_err", err, 0);
        rst = 0;

        // ALU op, load with 3 waits, store with immediate ack.
        do_op(32'h0, 32'h10, 32'h0, 32'h0, 5'd5, 0, 0, 0, 0, 1, 0, 0);
        do_op(32'h0, 32'h40, 32'h0, 32'hDEADBEEF, 5'd7, 1, 0, 0, 1, 1, 3, 0);
        do_op(32'h0, 32'h23, 32'h55, 32'h12345678, 5'd0, 0, 1, 0, 0, 0, 0, 0);
        // Back-to-back load then store.
        do_op(32'h0, 32'h104, 32'h0, 32'hCAFEF00D, 5'd9, 1, 0, 0, 1, 1, 0, 0);
        do_op(32'h0, 32'h10B, 32'hA5A5A5A5, 32'h11111111, 5'd3, 0, 1, 0, 0, 0, 0, 0);
        // Both read and write: treated as a write.
        do_op(32'h0, 32'h200, 32'h77, 32'h99999999, 5'd4, 1, 1, 0, 1, 1, 1, 0);
        // jal wrap and ack while idle.
        do_op(32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 5'd31, 0, 0, 1, 0, 1, 0, 0);
        do_op(32'h8, 32'h3C, 32'h0, 32'hFFFFFFFF, 5'd2, 0, 0, 0, 0, 1, 0, 1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            do_op($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  kind[0], kind[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset while in REQ abandons the access.
        clear_inputs();
        alures = 32'h80; mread = 1; rw = 1; m2r = 1; regdst = 5'd6;
        step;
        check("mid_req_on", req, 1);
        clear_inputs();
        rst = 1;
        step;
        rst = 0;
        check("mid_rst_req", req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_rw", o_rw, 0);
        check("mid_rst_wrd", wrd, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
        clear_inputs();
        alures = 32'h44; mread = 1; rw = 1; m2r = 1; regdst = 5'd8; rdata = 32'h5A5A5A5A;
        pc4 = 32'h100;
        step;
        for (int i = 0; i < 15; i++) begin
            check("to_wait_stall", stall, 1);
            step;
        end
        check("to_release_stall", stall, 0);
        step;
        clear_inputs();
        check("to_err", err, 1);
        check("to_req", req, 0);
        check("to_rw", o_rw, 0);
        check("to_memout", memout, 0);
        check("to_result", result, 32'h44);
        step;
        check("to_err_sticky", err, 1);
`else
        do_op(32'h0, 32'h300, 32'h0, 32'h0BADF00D, 5'd12, 1, 0, 0, 1, 1, 20, 0);
        check("no_to_err", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
